// File: rtl/crossbar_scheduler_if.sv
// Request/issue bundle between the batch source, the crossbar scheduler and the APE side.
`ifndef INPUT_CHANNEL
`define INPUT_CHANNEL 4
`endif
`ifndef OUTPUT_CHANNEL
`define OUTPUT_CHANNEL 4
`endif

interface crossbar_scheduler_if #(
  parameter int unsigned IN_CH  = `INPUT_CHANNEL,
  parameter int unsigned OUT_CH = `OUTPUT_CHANNEL
);
  localparam int unsigned OCW = $clog2(OUT_CH);
  localparam int unsigned BW  = $clog2(IN_CH + 1);

  logic                          req_valid;
  logic                          req_ready;
  logic [IN_CH-1:0]              req_mask;
  logic [IN_CH-1:0][OCW-1:0]     req_oc;
  logic                          issue_valid;
  logic                          issue_ready;
  logic [IN_CH-1:0]              is_index;
  logic [IN_CH-1:0][OCW-1:0]     indices_output_channel;
  logic                          batch_done;
  logic [BW-1:0]                 batch_beats;

  modport master (
    output req_valid, req_mask, req_oc, issue_ready,
    input  req_ready, issue_valid, is_index, indices_output_channel, batch_done, batch_beats
  );

  modport slave (
    input  req_valid, req_mask, req_oc, issue_ready,
    output req_ready, issue_valid, is_index, indices_output_channel, batch_done, batch_beats
  );
endinterface

// File: rtl/crossbar_scheduler.sv
// Serialises one batch of input->output channel requests onto the crossbar so that
// no output channel is driven by two inputs in the same beat (lowest input index wins).
`ifndef INPUT_CHANNEL
`define INPUT_CHANNEL 4
`endif
`ifndef OUTPUT_CHANNEL
`define OUTPUT_CHANNEL 4
`endif

module crossbar_scheduler #(
  parameter int unsigned IN_CH  = `INPUT_CHANNEL,
  parameter int unsigned OUT_CH = `OUTPUT_CHANNEL
) (
  input  logic                  clock,
  input  logic                  reset,
  crossbar_scheduler_if.slave   bus
);
  localparam int unsigned OCW = $clog2(OUT_CH);
  localparam int unsigned BW  = $clog2(IN_CH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t                    state_q, state_d;
  logic [IN_CH-1:0]          pending_q, pending_d;
  logic [IN_CH-1:0][OCW-1:0] tgt_q, tgt_d;
  logic [BW-1:0]             beats_q, beats_d;
  logic                      issue_valid_q, issue_valid_d;
  logic [IN_CH-1:0]          is_index_q, is_index_d;
  logic [IN_CH-1:0][OCW-1:0] indices_q, indices_d;
  logic                      batch_done_q, batch_done_d;
  logic [BW-1:0]             batch_beats_q, batch_beats_d;

  logic [IN_CH-1:0]          grant;
  logic                      blocked;
  logic                      adv;

  // A pending channel is granted unless a lower-indexed pending channel targets the same output.
  always_comb begin
    grant   = '0;
    blocked = 1'b0;
    for (int i = 0; i < IN_CH; i++) begin
      blocked = 1'b0;
      for (int k = 0; k < i; k++) begin
        if (pending_q[k] && (tgt_q[k] == tgt_q[i])) blocked = 1'b1;
      end
      grant[i] = pending_q[i] && !blocked;
    end
  end

  assign adv = !issue_valid_q || bus.issue_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      tgt_q         <= '0;
      beats_q       <= '0;
      issue_valid_q <= 1'b0;
      is_index_q    <= '0;
      indices_q     <= '0;
      batch_done_q  <= 1'b0;
      batch_beats_q <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      tgt_q         <= tgt_d;
      beats_q       <= beats_d;
      issue_valid_q <= issue_valid_d;
      is_index_q    <= is_index_d;
      indices_q     <= indices_d;
      batch_done_q  <= batch_done_d;
      batch_beats_q <= batch_beats_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    tgt_d         = tgt_q;
    beats_d       = beats_q;
    issue_valid_d = issue_valid_q;
    is_index_d    = is_index_q;
    indices_d     = indices_q;
    batch_done_d  = 1'b0;
    batch_beats_d = batch_beats_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          pending_d = bus.req_mask;
          tgt_d     = bus.req_oc;
          beats_d   = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        // Outputs only move once the current select set has been consumed.
        if (adv) begin
          if (|pending_q) begin
            is_index_d    = grant;
            for (int i = 0; i < IN_CH; i++) begin
              indices_d[i] = grant[i] ? tgt_q[i] : OCW'(0);
            end
            issue_valid_d = 1'b1;
            pending_d     = pending_q & ~grant;
            beats_d       = beats_q + BW'(1);
          end else begin
            issue_valid_d = 1'b0;
            is_index_d    = '0;
            indices_d     = '0;
            batch_done_d  = 1'b1;
            batch_beats_d = beats_q;
            state_d       = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.req_ready              = (state_q == IDLE) && !reset;
  assign bus.issue_valid            = issue_valid_q;
  assign bus.is_index               = is_index_q;
  assign bus.indices_output_channel = indices_q;
  assign bus.batch_done             = batch_done_q;
  assign bus.batch_beats            = batch_beats_q;

endmodule

// File: tb/tb_crossbar_scheduler.sv
// Directed bench for crossbar_scheduler (IN_CH = OUT_CH = 4) with cycle-exact expectations.
module tb_crossbar_scheduler;
  localparam int unsigned IN_CH  = 4;
  localparam int unsigned OUT_CH = 4;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_err;

  crossbar_scheduler_if #(.IN_CH(IN_CH), .OUT_CH(OUT_CH)) bus ();

  crossbar_scheduler #(.IN_CH(IN_CH), .OUT_CH(OUT_CH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observation word: {issue_valid, is_index, indices, batch_done, beats-while-done, req_ready}
  function automatic logic [17:0] snap();
    logic [2:0] bb;
    bb = bus.batch_done ? bus.batch_beats : 3'd0;
    return {bus.issue_valid, bus.is_index, bus.indices_output_channel, bus.batch_done, bb, bus.req_ready};
  endfunction

  function automatic logic [17:0] mk(logic iv, logic [3:0] idx, logic [7:0] ind,
                                     logic bd, logic [2:0] bb, logic rr);
    return {iv, idx, ind, bd, bb, rr};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Presents one batch for a single cycle; returns just after the accepting edge.
  task automatic offer(input logic [3:0] mask, input logic [7:0] oc);
    bus.req_valid = 1'b1;
    bus.req_mask  = mask;
    bus.req_oc    = oc;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [17:0] got;
    reset = 1'b1;
    repeat (3) step();
    got = {bus.issue_valid, bus.is_index, bus.indices_output_channel,
           bus.batch_done, bus.batch_beats, bus.req_ready};
    n_vec++;
    if (got !== 18'h0) begin
      n_err++;
      $display("FAIL reset_hold: got %h exp %h", got, 18'h0);
    end
    reset = 1'b0;
    step();
    n_vec++;
    if (snap() !== mk(0, 4'h0, 8'h00, 0, 3'd0, 1)) begin
      n_err++;
      $display("FAIL reset_release: got %h exp %h", snap(), mk(0, 4'h0, 8'h00, 0, 3'd0, 1));
    end
  endtask

  // ch0..ch3 -> 0,1,2,3; a busy-time offer with another mask must be ignored.
  task automatic test_no_conflict();
    offer(4'b1111, {2'd3, 2'd2, 2'd1, 2'd0});
    bus.req_valid = 1'b1;
    bus.req_mask  = 4'b0001;
    bus.req_oc    = 8'h00;
    n_vec++;
    if (snap() !== mk(0, 4'h0, 8'h00, 0, 3'd0, 0)) begin
      n_err++;
      $display("FAIL nc_accept: got %h exp %h", snap(), mk(0, 4'h0, 8'h00, 0, 3'd0, 0));
    end
    step();
    n_vec++;
    if (snap() !== mk(1, 4'b1111, 8'he4, 0, 3'd0, 0)) begin
      n_err++;
      $display("FAIL nc_beat: got %h exp %h", snap(), mk(1, 4'b1111, 8'he4, 0, 3'd0, 0));
    end
    step();
    bus.req_valid = 1'b0;
    n_vec++;
    if (snap() !== mk(0, 4'h0, 8'h00, 1, 3'd1, 0)) begin
      n_err++;
      $display("FAIL nc_done: got %h exp %h", snap(), mk(0, 4'h0, 8'h00, 1, 3'd1, 0));
    end
    step();
    n_vec++;
    if (snap() !== mk(0, 4'h0, 8'h00, 0, 3'd0, 1)) begin
      n_err++;
      $display("FAIL nc_idle: got %h exp %h", snap(), mk(0, 4'h0, 8'h00, 0, 3'd0, 1));
    end
  endtask

  // ch0=2, ch1=2, ch2=0, ch3=2 -> beats 0101, 0010, 1000.
  task automatic test_conflicts();
    logic [17:0] exp_seq [5];
    logic [3:0]  or_acc;
    exp_seq[0] = mk(1, 4'b0101, 8'h02, 0, 3'd0, 0);
    exp_seq[1] = mk(1, 4'b0010, 8'h08, 0, 3'd0, 0);
    exp_seq[2] = mk(1, 4'b1000, 8'h80, 0, 3'd0, 0);
    exp_seq[3] = mk(0, 4'h0, 8'h00, 1, 3'd3, 0);
    exp_seq[4] = mk(0, 4'h0, 8'h00, 0, 3'd0, 1);
    or_acc = 4'h0;
    offer(4'b1111, {2'd2, 2'd0, 2'd2, 2'd2});
    for (int c = 0; c < 5; c++) begin
      step();
      if (bus.issue_valid) or_acc = or_acc | bus.is_index;
      n_vec++;
      if (snap() !== exp_seq[c]) begin
        n_err++;
        $display("FAIL conflict_cycle%0d: got %h exp %h", c, snap(), exp_seq[c]);
      end
    end
    n_vec++;
    if (or_acc !== 4'b1111) begin
      n_err++;
      $display("FAIL conflict_cover: got %b exp %b", or_acc, 4'b1111);
    end
  endtask

  task automatic test_backpressure();
    offer(4'b1111, {2'd2, 2'd0, 2'd2, 2'd2});
    step();
    n_vec++;
    if (snap() !== mk(1, 4'b0101, 8'h02, 0, 3'd0, 0)) begin
      n_err++;
      $display("FAIL bp_beat1: got %h exp %h", snap(), mk(1, 4'b0101, 8'h02, 0, 3'd0, 0));
    end
    step();
    bus.issue_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_vec++;
      if (snap() !== mk(1, 4'b0010, 8'h08, 0, 3'd0, 0)) begin
        n_err++;
        $display("FAIL bp_hold%0d: got %h exp %h", c, snap(), mk(1, 4'b0010, 8'h08, 0, 3'd0, 0));
      end
      if (c < 4) step();
    end
    bus.issue_ready = 1'b1;
    step();
    n_vec++;
    if (snap() !== mk(1, 4'b1000, 8'h80, 0, 3'd0, 0)) begin
      n_err++;
      $display("FAIL bp_beat3: got %h exp %h", snap(), mk(1, 4'b1000, 8'h80, 0, 3'd0, 0));
    end
    step();
    n_vec++;
    if (snap() !== mk(0, 4'h0, 8'h00, 1, 3'd3, 0)) begin
      n_err++;
      $display("FAIL bp_done: got %h exp %h", snap(), mk(0, 4'h0, 8'h00, 1, 3'd3, 0));
    end
    step();
  endtask

  task automatic test_empty_batch();
    offer(4'b0000, 8'h00);
    n_vec++;
    if (snap() !== mk(0, 4'h0, 8'h00, 0, 3'd0, 0)) begin
      n_err++;
      $display("FAIL empty_accept: got %h exp %h", snap(), mk(0, 4'h0, 8'h00, 0, 3'd0, 0));
    end
    step();
    n_vec++;
    if (snap() !== mk(0, 4'h0, 8'h00, 1, 3'd0, 0)) begin
      n_err++;
      $display("FAIL empty_done: got %h exp %h", snap(), mk(0, 4'h0, 8'h00, 1, 3'd0, 0));
    end
    step();
    n_vec++;
    if (snap() !== mk(0, 4'h0, 8'h00, 0, 3'd0, 1)) begin
      n_err++;
      $display("FAIL empty_idle: got %h exp %h", snap(), mk(0, 4'h0, 8'h00, 0, 3'd0, 1));
    end
  endtask

  task automatic test_reset_mid_batch();
    offer(4'b1111, {2'd2, 2'd0, 2'd2, 2'd2});
    step();
    step();
    n_vec++;
    if (snap() !== mk(1, 4'b0010, 8'h08, 0, 3'd0, 0)) begin
      n_err++;
      $display("FAIL rst_mid_beat2: got %h exp %h", snap(), mk(1, 4'b0010, 8'h08, 0, 3'd0, 0));
    end
    reset = 1'b1;
    step();
    n_vec++;
    if (snap() !== mk(0, 4'h0, 8'h00, 0, 3'd0, 0)) begin
      n_err++;
      $display("FAIL rst_mid_clear: got %h exp %h", snap(), mk(0, 4'h0, 8'h00, 0, 3'd0, 0));
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_vec++;
      if (snap() !== mk(0, 4'h0, 8'h00, 0, 3'd0, 1)) begin
        n_err++;
        $display("FAIL rst_mid_quiet%0d: got %h exp %h", c, snap(), mk(0, 4'h0, 8'h00, 0, 3'd0, 1));
      end
    end
    offer(4'b0110, {2'd0, 2'd3, 2'd3, 2'd0});
    step();
    n_vec++;
    if (snap() !== mk(1, 4'b0010, 8'h0c, 0, 3'd0, 0)) begin
      n_err++;
      $display("FAIL rst_after_beat1: got %h exp %h", snap(), mk(1, 4'b0010, 8'h0c, 0, 3'd0, 0));
    end
    step();
    n_vec++;
    if (snap() !== mk(1, 4'b0100, 8'h30, 0, 3'd0, 0)) begin
      n_err++;
      $display("FAIL rst_after_beat2: got %h exp %h", snap(), mk(1, 4'b0100, 8'h30, 0, 3'd0, 0));
    end
    step();
    n_vec++;
    if (snap() !== mk(0, 4'h0, 8'h00, 1, 3'd2, 0)) begin
      n_err++;
      $display("FAIL rst_after_done: got %h exp %h", snap(), mk(0, 4'h0, 8'h00, 1, 3'd2, 0));
    end
    step();
  endtask

  initial begin
    n_vec           = 0;
    n_err           = 0;
    reset           = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_mask    = '0;
    bus.req_oc      = '0;
    bus.issue_ready = 1'b1;
    test_reset();
    test_no_conflict();
    test_conflicts();
    test_backpressure();
    test_empty_batch();
    test_reset_mid_batch();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
